// File: rtl/gate_lab_pkg.sv
// Shared mode codes, FSM encoding and the 2-input NAND primitive with NAND-only helpers.
// Purely declarative; no latency or backpressure of its own.
package gate_lab_pkg;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_NAND = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;
    localparam logic [2:0] MODE_NOT  = 3'd6;
    localparam logic [2:0] MODE_BUF  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The one primitive: a lookup, so no logic operator appears anywhere in the gate path.
    function automatic logic nand2(input logic a, input logic b);
        case ({a, b})
            2'b11:   nand2 = 1'b0;
            default: nand2 = 1'b1;
        endcase
    endfunction

    function automatic logic inv1(input logic a);
        inv1 = nand2(a, a);
    endfunction

    function automatic logic and2(input logic a, input logic b);
        and2 = inv1(nand2(a, b));
    endfunction

    function automatic logic or2(input logic a, input logic b);
        or2 = nand2(inv1(a), inv1(b));
    endfunction

    function automatic logic xor2(input logic a, input logic b);
        logic t;
        t = nand2(a, b);
        xor2 = nand2(nand2(a, t), nand2(b, t));
    endfunction

    // s = 0 selects d0, s = 1 selects d1.
    function automatic logic mux2(input logic d0, input logic d1, input logic s);
        mux2 = nand2(nand2(d0, inv1(s)), nand2(d1, s));
    endfunction

endpackage

// File: rtl/nand_gate_core.sv
// N-input gate of selectable function, NAND-only networks plus an 8:1 NAND mux tree.
// Latency: combinational; backpressure: none.
module nand_gate_core
    import gate_lab_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [N_IN-1:0] vec,
    input  logic [2:0]      mode,
    output logic            y
);

    logic       acc_and;
    logic       acc_or;
    logic       acc_xor;
    logic [7:0] fn;
    logic [3:0] lvl0;
    logic [1:0] lvl1;

    always_comb begin
        acc_and = vec[0];
        acc_or  = vec[0];
        acc_xor = vec[0];
        for (int i = 1; i < N_IN; i++) begin
            acc_and = and2(acc_and, vec[i]);
            acc_or  = or2(acc_or, vec[i]);
            acc_xor = xor2(acc_xor, vec[i]);
        end

        fn            = '0;
        fn[MODE_AND]  = acc_and;
        fn[MODE_OR]   = acc_or;
        fn[MODE_NAND] = inv1(acc_and);
        fn[MODE_NOR]  = inv1(acc_or);
        fn[MODE_XOR]  = acc_xor;
        fn[MODE_XNOR] = inv1(acc_xor);
        fn[MODE_NOT]  = inv1(vec[0]);
        fn[MODE_BUF]  = vec[0];

        lvl0 = '0;
        lvl1 = '0;
        for (int j = 0; j < 4; j++) begin
            lvl0[j] = mux2(fn[2*j], fn[2*j+1], mode[0]);
        end
        for (int j = 0; j < 2; j++) begin
            lvl1[j] = mux2(lvl0[2*j], lvl0[2*j+1], mode[1]);
        end
        y = mux2(lvl1[0], lvl1[1], mode[2]);
    end

endmodule

// File: rtl/nand_gate_sweeper.sv
// Sweeps every input combination through nand_gate_core, capturing truth table and ones count.
// Latency: start to done 2^N_IN+1 cycles; start outside IDLE is dropped, no queueing.
module nand_gate_sweeper
    import gate_lab_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           mode,
    output logic                 busy,
    output logic                 done,
    output logic [N_IN-1:0]      vec,
    output logic                 gate_out,
    output logic [2**N_IN-1:0]   tt,
    output logic [N_IN:0]        ones
);

    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] mode_q;
    logic       last;

    nand_gate_core #(.N_IN(N_IN)) u_core (
        .vec  (vec),
        .mode (mode_q),
        .y    (gate_out)
    );

    assign last = (vec == VEC_LAST);
    assign busy = (state == ST_SWEEP);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SWEEP;
            ST_SWEEP: if (last)  state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The terminal compare stops the counter at VEC_LAST; DONE parks it back at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_AND;
            vec    <= '0;
            tt     <= '0;
            ones   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        vec    <= '0;
                        tt     <= '0;
                        ones   <= '0;
                    end
                end
                ST_SWEEP: begin
                    tt[vec] <= gate_out;
                    ones    <= ones + {{N_IN{1'b0}}, gate_out};
                    if (!last) begin
                        vec <= vec + VEC_ONE;
                    end
                end
                ST_DONE: begin
                    vec <= '0;
                end
                default: begin
                    vec <= '0;
                end
            endcase
        end
    end

endmodule
